regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Shares the single write port of the 4-entry x 16-bit register file between two requesters. Requester 0 is ALU writeback and requester 1 is the load/IO unit. Arbitration is round-robin with a valid/ready handshake and the write is registered. The block also contains a clear sequencer that zeroes all entries through the same port. It sits directly in front of the register file's write-flag, write-address and write-data inputs. The register file commits writes on the falling edge of the cycle in which wr_en is high.

Parameters:
DATA_W, 16, write data width
ADDR_W, 2, register address width
NUM_REGS, 4, number of entries swept by the clear sequencer (must be at most 2**ADDR_W)
CNT_W, 8, width of the saturating conflict counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  reset, synchronous, active-high
req0_valid  in  1  requester 0 has a write pending
req0_addr  in  ADDR_W  requester 0 target register
req0_data  in  DATA_W  requester 0 write data
req0_ready  out  1  requester 0 granted this cycle
req1_valid  in  1  requester 1 has a write pending
req1_addr  in  ADDR_W  requester 1 target register
req1_data  in  DATA_W  requester 1 write data
req1_ready  out  1  requester 1 granted this cycle
clr_start  in  1  pulse: clear all registers
clr_busy  out  1  clear sweep in progress
wr_en  out  1  to register file write flag
wr_addr  out  ADDR_W  to register file write address
wr_data  out  DATA_W  to register file write data
last_grant  out  1  id of the most recent granted requester
conflict_cnt  out  CNT_W  count of cycles with both valid while in IDLE, saturating

Behaviour:
- Reset (checked at a rising edge with reset=1) forces: wr_en=0, wr_addr=0, wr_data=0, clr_busy=0, last_grant=1, conflict_cnt=0, state=IDLE, sweep counter=0. With last_grant=1, requester 0 wins first.
- reset takes priority over every other input, including mid-sweep and mid-transfer; no partial sweep resumes afterwards.
- States: IDLE and CLEAR.
- req*_ready is combinational from current state, valids and last_grant. It is 0 in CLEAR.
- In IDLE:
  - only one valid: that requester is granted.
  - both valid: grant goes to the requester != last_grant.
- A transfer occurs when valid && ready are both high at a rising edge. At most one transfer per cycle.
- On a transfer edge: wr_en<=1, wr_addr<=granted addr, wr_data<=granted data, last_grant<=granted id. Latency is 1 cycle; the register file writes on the falling edge of that next cycle.
- No transfer and not CLEAR: wr_en<=0; wr_addr and wr_data hold their values.
- Requesters hold valid, addr and data stable until ready. Dropping valid before a grant is permitted; nothing is written.
- Both requesters targeting the same address: no special case. Each is written in its granted order, so the last written value persists.
- IDLE to CLEAR: on clr_start=1.
  - clr_start takes priority over requests in the same cycle; both ready=0 that cycle.
  - clr_busy<=1, sweep counter<=0.
- In CLEAR, each edge:
  - wr_en<=1, wr_addr<=counter, wr_data<=0, counter++.
  - When the counter reaches NUM_REGS-1 it is issued and state<=IDLE, clr_busy<=0, counter<=0.
  - The sweep is exactly NUM_REGS write cycles.
- clr_start is ignored while in CLEAR; it does not restart the sweep.
- last_grant is unchanged by a sweep.
- conflict_cnt increments in IDLE when req0_valid && req1_valid. It saturates at 2**CNT_W-1 and never wraps.

Test Plan:
- Reset then single write: req0 valid, addr=2, data=16'hBEEF. req0_ready=1 the same cycle; next cycle wr_en=1, wr_addr=2, wr_data=16'hBEEF; the cycle after, wr_en=0.
- Both requesters valid for 4 cycles, both re-asserting after each grant. Grants go req0, req1, req0, req1; last_grant ends at 1; conflict_cnt=4.
- clr_start while both requesters are valid:
  - clr_busy=1 for 4 cycles with wr_addr 0,1,2,3 and wr_data=0.
  - ready stays 0 throughout.
  - A second clr_start mid-sweep has no effect; after the sweep, arbitration resumes with the pre-sweep last_grant.
- Reset asserted at the second sweep cycle: the next cycle shows wr_en=0, clr_busy=0, state IDLE, with no further clear writes.
- Saturation with CNT_W=2 and both requesters valid for 6 cycles: conflict_cnt reads 1,2,3,3,3,3.
- req1 drops valid while req0 holds the grant: no req1 write occurs; subsequent single req0 requests are granted every cycle back-to-back, with wr_en high continuously.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin share of the register file write port between
// ALU writeback (req0) and load/IO (req1), with a clear sequencer on the same port.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter int NUM_REGS = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep;
  logic              open;
  // clr_start steals the cycle from both requesters
  assign open       = state == IDLE && !clr_start;
  assign req0_ready = open && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = open && req1_valid && (!req0_valid || !last_grant);
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sweep        <= '0;
      clr_busy     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      if (state == IDLE && req0_valid && req1_valid && conflict_cnt != {CNT_W{1'b1}})
        conflict_cnt <= conflict_cnt + 1'b1;
      if (state == CLEAR) begin
        wr_en   <= 1'b1;
        wr_addr <= sweep;
        wr_data <= '0;
        if (sweep == ADDR_W'(NUM_REGS - 1)) begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          sweep    <= '0;
        end else begin
          sweep <= sweep + 1'b1;
        end
      end else if (clr_start) begin
        state    <= CLEAR;
        clr_busy <= 1'b1;
        sweep    <= '0;
        wr_en    <= 1'b0;
      end else if (req0_ready || req1_ready) begin
        wr_en      <= 1'b1;
        wr_addr    <= req1_ready ? req1_addr : req0_addr;
        wr_data    <= req1_ready ? req1_data : req0_data;
        last_grant <= req1_ready;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: scoreboard bench; driver pushes per-cycle expectations from
// a behavioural model, monitor pops and compares after each rising edge.
module tb_regfile_wr_arbiter;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic        req0_valid = 0, req1_valid = 0, clr_start = 0;
  logic [1:0]  req0_addr = 0, req1_addr = 0;
  logic [15:0] req0_data = 0, req1_data = 0;
  logic        req0_ready, req1_ready, clr_busy, wr_en, last_grant;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  conflict_cnt;
  logic        s_r0, s_r1, s_busy, s_en, s_lg;
  logic [1:0]  s_addr, s_cnt;
  logic [15:0] s_data;

  regfile_wr_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  regfile_wr_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_r1),
    .clr_start(clr_start), .clr_busy(s_busy),
    .wr_en(s_en), .wr_addr(s_addr), .wr_data(s_data),
    .last_grant(s_lg), .conflict_cnt(s_cnt)
  );

  typedef struct {
    logic        en;
    logic [1:0]  addr;
    logic [15:0] data;
    logic        busy;
    logic        lg;
    int          c8;
    int          c2;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;

  int          m_sweep = -1;
  logic        m_lg = 1;
  int          m_c8 = 0, m_c2 = 0;
  logic [1:0]  m_addr = 0;
  logic [15:0] m_data = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic v0, input logic [1:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [1:0] a1, input logic [15:0] d1,
                       input logic cs, input logic rst, output logic g0, output logic g1);
    logic e0, e1;
    exp_t x;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clr_start = cs; reset = rst;
    #1;
    e0 = 0; e1 = 0;
    if (m_sweep < 0 && !cs) begin
      if (v0 && v1) begin e0 = m_lg; e1 = !m_lg; end
      else begin e0 = v0; e1 = v1; end
    end
    if (!rst) begin
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("sat_req0_ready", s_r0, e0);
    end
    if (rst) begin
      m_sweep = -1; m_lg = 1; m_c8 = 0; m_c2 = 0; m_addr = 0; m_data = 0; x.en = 0;
    end else if (m_sweep >= 0) begin
      x.en = 1; m_addr = 2'(m_sweep); m_data = 0;
      m_sweep = (m_sweep == 3) ? -1 : m_sweep + 1;
    end else begin
      if (v0 && v1) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
      if (cs) begin
        m_sweep = 0; x.en = 0;
      end else if (e0 || e1) begin
        x.en = 1; m_addr = e1 ? a1 : a0; m_data = e1 ? d1 : d0; m_lg = e1;
      end else x.en = 0;
    end
    x.addr = m_addr; x.data = m_data; x.busy = m_sweep >= 0; x.lg = m_lg;
    x.c8 = m_c8; x.c2 = m_c2;
    q.push_back(x);
    g0 = e0 && !rst;
    g1 = e1 && !rst;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("wr_en", wr_en, x.en);
        chk("wr_addr", wr_addr, x.addr);
        chk("wr_data", wr_data, x.data);
        chk("clr_busy", clr_busy, x.busy);
        chk("last_grant", last_grant, x.lg);
        chk("conflict_cnt", conflict_cnt, x.c8);
        chk("conflict_cnt_sat", s_cnt, x.c2);
        chk("sat_wr_en", s_en, x.en);
      end
    end
  end

  initial begin
    logic g0, g1, p0, p1, cs, rst;
    logic [1:0] ra0, ra1;
    logic [15:0] rd0, rd1;
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
    cycle(1, 2, 16'hBEEF, 0, 0, 0, 0, 0, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
    repeat (6) cycle(1, 1, 16'h1111, 1, 3, 16'h2222, 0, 0, g0, g1);
    cycle(1, 0, 16'h3333, 1, 2, 16'h4444, 1, 0, g0, g1);
    cycle(1, 0, 16'h3333, 1, 2, 16'h4444, 0, 0, g0, g1);
    cycle(1, 0, 16'h3333, 1, 2, 16'h4444, 1, 0, g0, g1);
    repeat (4) cycle(1, 0, 16'h3333, 1, 2, 16'h4444, 0, 0, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    cycle(1, 3, 16'hA5A5, 1, 3, 16'h5A5A, 0, 0, g0, g1);
    cycle(1, 1, 16'h0001, 0, 3, 16'h5A5A, 0, 0, g0, g1);
    for (int i = 0; i < 4; i++) cycle(1, 2'(i), 16'(16'h0100 + i), 0, 0, 0, 0, 0, g0, g1);
    p0 = 0; p1 = 0; ra0 = 0; ra1 = 0; rd0 = 0; rd1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; ra0 = 2'($urandom); rd0 = 16'($urandom); end
      else if (p0 && $urandom_range(0, 15) == 0) p0 = 0;
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; ra1 = 2'($urandom); rd1 = 16'($urandom); end
      else if (p1 && $urandom_range(0, 15) == 0) p1 = 0;
      cs = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 299) == 0;
      cycle(p0, ra0, rd0, p1, ra1, rd1, cs, rst, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    repeat (3) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
